// File: rtl/fpacc.sv
// fpacc: streaming binary32 vector accumulator.
// One AL-deep FP adder is time-shared between AL interleaved partial sums
// while a vector streams in. The partials are then reduced in fixed order,
// and the result is presented on a valid/ready output.
// Optional feature: define FPACC_CNT_EN to add the o_cnt element counter.
module fpacc #(
  parameter int    DW = 32,
  parameter int    AL = 3,
  parameter string OP = "ADD",
  parameter int    CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  input  logic          i_lst,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat
`ifdef FPACC_CNT_EN
  ,
  output logic [CW-1:0] o_cnt
`endif
);

  localparam int SW = (AL > 1) ? $clog2(AL) : 1;

  if (DW != 32 || AL < 1 || AL > 8 || CW < 1) begin : g_bad_param
    $error("fpacc: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_REDUCE, S_OUT} state_t;

  // binary32 add: RNE, subnormals flushed to +0, Inf/NaN per IEEE.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, big, sml;
    logic [26:0] mb, ms, mx;
    logic [27:0] sum;
    logic [24:0] mr;
    logic [7:0]  d;
    logic [4:0]  lz;
    logic        a_nan, b_nan, a_inf, b_inf, a_z, b_z, rnd;
    int          er;
    r     = 32'h0;
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    a_inf = (&a[30:23]) && !(|a[22:0]);
    b_inf = (&b[30:23]) && !(|b[22:0]);
    a_z   = (a[30:23] == 8'h00);
    b_z   = (b[30:23] == 8'h00);
    if (a_nan || b_nan)      r = 32'h7FC0_0000;
    else if (a_inf && b_inf) r = (a[31] != b[31]) ? 32'h7FC0_0000 : a;
    else if (a_inf)          r = a;
    else if (b_inf)          r = b;
    else if (a_z && b_z)     r = (a == 32'h8000_0000 && b == 32'h8000_0000) ? a : 32'h0;
    else if (a_z)            r = b;
    else if (b_z)            r = a;
    else begin
      // Align the smaller magnitude onto the larger; 3 extra bits hold guard/round/sticky.
      if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
      else                    begin big = b; sml = a; end
      mb = {1'b1, big[22:0], 3'b000};
      ms = {1'b1, sml[22:0], 3'b000};
      d  = big[30:23] - sml[30:23];
      if (d >= 8'd27) mx = 27'd1;
      else begin
        mx    = ms >> d;
        mx[0] = mx[0] | (|(ms & ((27'd1 << d) - 27'd1)));
      end
      er = int'(big[30:23]);
      if (big[31] == sml[31]) sum = {1'b0, mb} + {1'b0, mx};
      else                    sum = {1'b0, mb} - {1'b0, mx};
      if (sum == 28'd0) r = 32'h0;
      else begin
        if (sum[27]) begin
          sum = {1'b0, sum[27:2], sum[1] | sum[0]};
          er  = er + 1;
        end else begin
          lz = 5'd0;
          for (int i = 0; i <= 26; i++) if (sum[i]) lz = 5'(26 - i);
          sum = sum << lz;
          er  = er - int'(lz);
        end
        rnd = sum[2] && (sum[1] || sum[0] || sum[3]);
        mr  = {1'b0, sum[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
          mr = {1'b0, mr[24:1]};
          er = er + 1;
        end
        if (er <= 0)        r = 32'h0;
        else if (er >= 255) r = {big[31], 8'hFF, 23'h0};
        else                r = {big[31], er[7:0], mr[22:0]};
      end
    end
    return r;
  endfunction

  state_t        state, state_nxt;
  logic [SW-1:0] slot, sub, red_k;
  logic [DW-1:0] part  [AL];
  logic [DW-1:0] p_dat [AL];
  logic [DW-1:0] p_nxt [AL];
  logic          p_vld [AL];
  logic          p_wr  [AL];
  logic [SW-1:0] p_tag [AL];
  logic [DW-1:0] op_a, op_b, x, sum_c, res_val;
  logic          iss_vld, iss_wr, accept, handshake, load_res;

  assign accept    = (state == S_ACC) && i_vld;
  assign handshake = (state == S_OUT) && o_rdy;
  assign load_res  = (state != S_OUT) && (state_nxt == S_OUT);
  assign i_rdy     = (state == S_ACC);
  assign o_vld     = (state == S_OUT);

  // Select adder operands: streaming beat into its slot, or the next reduction step.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    x       = (OP == "SUB") ? {~i_dat[DW-1], i_dat[DW-2:0]} : i_dat;
    op_a    = (p_vld[AL-1] && p_wr[AL-1] && p_tag[AL-1] == slot) ? p_dat[AL-1] : part[slot];
    op_b    = x;
    iss_vld = 1'b0;
    iss_wr  = 1'b0;
    if (accept) begin
      iss_vld = 1'b1;
      iss_wr  = 1'b1;
    end else if (state == S_REDUCE && sub == '0) begin
      iss_vld = 1'b1;
      op_a    = (red_k == SW'(1)) ? part[0] : p_dat[AL-1];
      op_b    = part[red_k];
    end
    sum_c = fp_add(op_a, op_b);
    for (int i = 0; i < AL; i++) p_nxt[i] = (i == 0) ? sum_c : p_dat[(i > 0) ? i - 1 : 0];
    // The final sum is captured on the same edge it enters the last adder stage.
    res_val = (AL == 1) ? p_dat[AL-1] : p_nxt[AL-1];
  end

  // Next-state decode for ACC -> DRAIN -> REDUCE -> OUT -> ACC.
  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:    if (accept && i_lst) state_nxt = S_DRAIN;
      S_DRAIN:  if (sub == SW'(AL - 1)) state_nxt = (AL == 1) ? S_OUT : S_REDUCE;
      S_REDUCE: if (sub == SW'(AL - 1) && red_k == SW'(AL - 1)) state_nxt = S_OUT;
      S_OUT:    if (o_rdy) state_nxt = S_ACC;
      default:  state_nxt = S_ACC;
    endcase
  end

  // Control state, partial sums, adder valid pipe and result register.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ACC;
      slot  <= '0;
      sub   <= '0;
      red_k <= SW'(1);
      o_dat <= '0;
      // NOTE: the partial-sum array is reset explicitly; it is the accumulator, not scratch.
      for (int i = 0; i < AL; i++) begin
        part[i]  <= '0;
        p_vld[i] <= 1'b0;
      end
    end else begin
      state <= state_nxt;
      for (int i = 0; i < AL; i++) p_vld[i] <= (i == 0) ? iss_vld : p_vld[(i > 0) ? i - 1 : 0];
      if (handshake) begin
        for (int i = 0; i < AL; i++) part[i] <= '0;
        slot <= '0;
        sub  <= '0;
      end else if (p_vld[AL-1] && p_wr[AL-1]) begin
        part[p_tag[AL-1]] <= p_dat[AL-1];
      end
      if (accept) slot <= (slot == SW'(AL - 1)) ? '0 : slot + SW'(1);
      if (state == S_DRAIN || state == S_REDUCE) sub <= (sub == SW'(AL - 1)) ? '0 : sub + SW'(1);
      if (state == S_DRAIN) red_k <= SW'(1);
      else if (state == S_REDUCE && sub == SW'(AL - 1)) red_k <= red_k + SW'(1);
      if (load_res) o_dat <= res_val;
    end
  end

  // Adder data and tag stages; their validity is carried by p_vld.
  always_ff @(posedge clk) begin
    for (int i = 0; i < AL; i++) begin
      p_dat[i] <= p_nxt[i];
      p_wr[i]  <= (i == 0) ? iss_wr : p_wr[(i > 0) ? i - 1 : 0];
      p_tag[i] <= (i == 0) ? slot : p_tag[(i > 0) ? i - 1 : 0];
    end
  end

`ifdef FPACC_CNT_EN
  logic [CW-1:0] cnt;

  // Saturating beat counter, latched with the result and cleared on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      o_cnt <= '0;
    end else begin
      if (handshake) begin
        cnt   <= '0;
        o_cnt <= '0;
      end else if (accept && cnt != {CW{1'b1}}) begin
        cnt <= cnt + CW'(1);
      end
      if (load_res) o_cnt <= cnt;
    end
  end
`endif

endmodule

// File: tb/tb_fpacc.sv
// tb_fpacc: self-checking bench for fpacc with an ADD and a SUB instance
// driven from the same stream. Expected sums come from integer arithmetic
// converted to binary32, so they are exact regardless of summation order.
module tb_fpacc;
  localparam int AL = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, i_vld, i_lst, o_rdy;
  logic [31:0]   i_dat;
  logic          i_rdy_a, i_rdy_s, o_vld_a, o_vld_s;
  logic [31:0]   o_dat_a, o_dat_s;
`ifdef FPACC_CNT_EN
  logic [CW-1:0] o_cnt_a, o_cnt_s;
`endif

  fpacc #(.DW(32), .AL(AL), .OP("ADD"), .CW(CW)) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(i_rdy_a), .i_dat(i_dat), .i_lst(i_lst),
    .o_vld(o_vld_a), .o_rdy(o_rdy), .o_dat(o_dat_a)
`ifdef FPACC_CNT_EN
    , .o_cnt(o_cnt_a)
`endif
  );

  fpacc #(.DW(32), .AL(AL), .OP("SUB"), .CW(CW)) dut_sub (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(i_rdy_s), .i_dat(i_dat), .i_lst(i_lst),
    .o_vld(o_vld_s), .o_rdy(o_rdy), .o_dat(o_dat_s)
`ifdef FPACC_CNT_EN
    , .o_cnt(o_cnt_s)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] vbuf [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact binary32 encoding of an integer with magnitude below 2^24.
  function automatic logic [31:0] int_to_f32(input int n);
    logic [31:0] m, t;
    int          p;
    logic        s;
    if (n == 0) return 32'h0;
    s = (n < 0);
    m = s ? 32'(-n) : 32'(n);
    p = 0;
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    t = m << (23 - p);
    return {s, 8'(127 + p), t[22:0]};
  endfunction

  // Stream vbuf[0..n-1] as one vector, then collect and check the result.
  // gap_mode: 0 back-to-back, 1 bubble between beats, 2 random bubbles.
  task automatic run_vec(input int n, input int gap_mode, input int hold,
                         input logic [31:0] exp_a, input logic [31:0] exp_s, input string tag);
    int          t_lst, waited;
    bit          acc, rdy_low;
    logic [31:0] d0;
    t_lst = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
        i_vld = 1'b0;
        tick();
      end
      i_vld  = 1'b1;
      i_dat  = vbuf[i];
      i_lst  = (i == n - 1);
      waited = 0;
      do begin
        acc = i_rdy_a;
        tick();
        waited++;
      end while (!acc && waited < 20);
      check($sformatf("%s_accept%0d", tag, i), 32'(acc), 32'd1);
      if (i == 0) check($sformatf("%s_first_wait", tag), 32'(waited), 32'd1);
      if (i == n - 1) t_lst = cyc - 1;
    end
    i_vld = 1'b0;
    i_lst = 1'b0;
    o_rdy = 1'b0;
    rdy_low = 1'b1;
    waited  = 0;
    while (!o_vld_a && waited < 40) begin
      rdy_low = rdy_low && !i_rdy_a && !i_rdy_s;
      tick();
      waited++;
    end
    check($sformatf("%s_rdy_low", tag), 32'(rdy_low), 32'd1);
    check($sformatf("%s_vld", tag), 32'(o_vld_a), 32'd1);
    check($sformatf("%s_vld_sub", tag), 32'(o_vld_s), 32'd1);
    check($sformatf("%s_latency", tag), 32'(cyc - t_lst), 32'(AL * AL + 1));
    check($sformatf("%s_dat", tag), o_dat_a, exp_a);
    check($sformatf("%s_dat_sub", tag), o_dat_s, exp_s);
`ifdef FPACC_CNT_EN
    check($sformatf("%s_cnt", tag), 32'(o_cnt_a), 32'(n));
    check($sformatf("%s_cnt_sub", tag), 32'(o_cnt_s), 32'(n));
`endif
    d0 = o_dat_a;
    for (int h = 0; h < hold; h++) begin
      tick();
      check($sformatf("%s_hold_vld%0d", tag, h), 32'(o_vld_a), 32'd1);
      check($sformatf("%s_hold_dat%0d", tag, h), o_dat_a, d0);
      check($sformatf("%s_hold_rdy%0d", tag, h), 32'(i_rdy_a), 32'd0);
    end
    o_rdy = 1'b1;
    tick();
    o_rdy = 1'b0;
    check($sformatf("%s_vld_clr", tag), 32'(o_vld_a), 32'd0);
    check($sformatf("%s_rdy_back", tag), 32'(i_rdy_a), 32'd1);
  endtask

  initial begin
    int n, s;
    rst   = 1'b1;
    i_vld = 1'b0;
    i_dat = 32'h0;
    i_lst = 1'b0;
    o_rdy = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_i_rdy", 32'(i_rdy_a), 32'd1);
    check("reset_o_vld", 32'(o_vld_a), 32'd0);
    check("reset_o_dat", o_dat_a, 32'h0);
`ifdef FPACC_CNT_EN
    check("reset_o_cnt", 32'(o_cnt_a), 32'd0);
`endif

    for (int i = 0; i < 8; i++) vbuf[i] = int_to_f32(i + 1);
    run_vec(8, 0, 0, 32'h4210_0000, 32'hC210_0000, "seq1to8");

    vbuf[0] = 32'h4020_0000;
    run_vec(1, 0, 0, 32'h4020_0000, 32'hC020_0000, "single2p5");

    for (int i = 0; i < 4; i++) vbuf[i] = 32'h3F80_0000;
    run_vec(4, 1, 0, 32'h4080_0000, 32'hC080_0000, "gapped");

    vbuf[0] = 32'h4040_0000;
    vbuf[1] = 32'h4080_0000;
    run_vec(2, 0, 5, 32'h40E0_0000, 32'hC0E0_0000, "hold5");

    vbuf[0] = 32'h3FC0_0000;
    vbuf[1] = 32'h3F00_0000;
    run_vec(2, 0, 0, 32'h4000_0000, 32'hC000_0000, "frac");

    // Abort a vector mid-stream with reset.
    for (int i = 0; i < 3; i++) begin
      i_vld = 1'b1;
      i_dat = 32'h40A0_0000;
      i_lst = 1'b0;
      tick();
    end
    i_vld = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_i_rdy", 32'(i_rdy_a), 32'd1);
    check("midrst_o_vld", 32'(o_vld_a), 32'd0);
    check("midrst_o_dat", o_dat_a, 32'h0);
    repeat (4) tick();
    vbuf[0] = 32'h3F80_0000;
    run_vec(1, 0, 0, 32'h3F80_0000, 32'hBF80_0000, "after_rst");

    for (int v = 0; v < 8; v++) begin
      n = int'($urandom_range(1, 14));
      s = 0;
      for (int i = 0; i < n; i++) begin
        int e;
        e = int'($urandom_range(0, 2000)) - 1000;
        s = s + e;
        vbuf[i] = int_to_f32(e);
      end
      run_vec(n, 2, int'($urandom_range(0, 3)), int_to_f32(s), int_to_f32(-s),
              $sformatf("rand%0d", v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
